atm_txn_ctrl: RTL and testbench

// Session controller that drives the account RAM: fetches the card's account word,

---
 rtl/atm_txn_ctrl_pkg.sv | 48 ++++
 rtl/atm_idle_timer.sv | 28 ++
 rtl/atm_txn_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_atm_txn_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/atm_txn_ctrl_pkg.sv
// Shared definitions for the ATM session controller: FSM states, status codes,
// account-word field layout and default limits.
package atm_txn_ctrl_pkg;

    localparam int NUM_ACC_DEF     = 5;
    localparam int MAX_TRIES_DEF   = 3;
    localparam int MAX_WD_DEF      = 500;
    localparam int TIMEOUT_CYC_DEF = 1024;

    localparam int ADDR_W   = 5;
    localparam int LOCK_BIT = 31;
    localparam int PIN_MSB  = 13;
    localparam int PIN_LSB  = 10;
    localparam int BAL_MSB  = 9;
    localparam int BAL_LSB  = 0;
    localparam int PIN_W    = PIN_MSB - PIN_LSB + 1;
    localparam int BAL_W    = BAL_MSB - BAL_LSB + 1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH_ADDR,
        ST_FETCH_DATA,
        ST_WAIT_PIN,
        ST_LOCK,
        ST_MENU,
        ST_DEBIT,
        ST_EJECT
    } atm_state_t;

    typedef enum logic [2:0] {
        STAT_OK      = 3'd0,
        STAT_BAD_PIN = 3'd1,
        STAT_LOCKED  = 3'd2,
        STAT_INSUFF  = 3'd3,
        STAT_BAD_AMT = 3'd4,
        STAT_BAD_ACC = 3'd5,
        STAT_TIMEOUT = 3'd6
    } atm_status_t;

    function automatic logic [PIN_W-1:0] word_pin(input logic [31:0] w);
        return w[PIN_MSB:PIN_LSB];
    endfunction

    function automatic logic [BAL_W-1:0] word_bal(input logic [31:0] w);
        return w[BAL_MSB:BAL_LSB];
    endfunction

endpackage

// File: rtl/atm_idle_timer.sv
// Inactivity down-counter: reloads on clear, counts while enabled, and flags the
// cycle that completes TIMEOUT_CYC consecutive enabled cycles.
module atm_idle_timer #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expired
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= CNT_W'(TIMEOUT_CYC);
        end else if (en && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign expired = en && !clear && (cnt == CNT_W'(1));

endmodule

// File: rtl/atm_txn_ctrl.sv
// ATM session controller: fetches the card's account word, checks the PIN with
// lockout, serves inquiries and withdrawals, and writes debited balances back.
//
// state      | meaning
// IDLE       | no session, waiting for a card insertion edge
// FETCH_ADDR | account address on acc_addr, RAM read in flight
// FETCH_DATA | acc_info valid, shadow copy captured
// WAIT_PIN   | waiting for PIN entry
// LOCK       | lock_acc pulse on the bus
// MENU       | authenticated, serving requests
// DEBIT      | update pulse on the bus, dispense issued next
// EJECT      | session ended, waiting for card removal
module atm_txn_ctrl
    import atm_txn_ctrl_pkg::*;
#(
    parameter int NUM_ACC     = NUM_ACC_DEF,
    parameter int MAX_TRIES   = MAX_TRIES_DEF,
    parameter int MAX_WD      = MAX_WD_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              card_valid,
    input  logic [ADDR_W-1:0] card_acc,
    input  logic              pin_valid,
    input  logic [PIN_W-1:0]  pin_digits,
    input  logic              req_valid,
    input  logic              req_wd,
    input  logic [BAL_W-1:0]  req_amt,
    input  logic [31:0]       acc_info,
    output logic [ADDR_W-1:0] acc_addr,
    output logic              lock_acc,
    output logic              update,
    output logic [BAL_W-1:0]  balance,
    output logic              dispense,
    output logic [BAL_W-1:0]  disp_amt,
    output logic [BAL_W-1:0]  bal_out,
    output logic [2:0]        status,
    output logic              status_vld,
    output logic              busy
);
    localparam int TRY_W = $clog2(MAX_TRIES + 1);
    localparam logic [ADDR_W-1:0] LAST_ACC = ADDR_W'(NUM_ACC - 1);
    localparam logic [BAL_W-1:0]  MAX_AMT  = BAL_W'(MAX_WD);

    atm_state_t        state, state_nxt;
    logic              card_q;
    logic [PIN_W-1:0]  shadow_pin, pin_nxt;
    logic [BAL_W-1:0]  shadow_bal, sbal_nxt;
    logic [BAL_W-1:0]  amt_q, amt_nxt;
    logic [TRY_W-1:0]  tries, tries_nxt, tries_inc;
    logic [ADDR_W-1:0] acc_addr_nxt;
    logic              lock_nxt, update_nxt, dispense_nxt, status_vld_nxt;
    logic [BAL_W-1:0]  balance_nxt, disp_amt_nxt, bal_out_nxt;
    logic [2:0]        status_nxt;

    logic card_rise, in_wait, strobe, timer_clear, timer_en, timer_expired;
    logic unused_word_bits;

    assign card_rise   = card_valid && !card_q;
    assign in_wait     = (state == ST_WAIT_PIN) || (state == ST_MENU);
    assign strobe      = pin_valid || req_valid;
    assign timer_clear = strobe || !in_wait;
    assign timer_en    = in_wait;
    assign tries_inc   = tries + TRY_W'(1);
    assign busy        = (state != ST_IDLE);

    assign unused_word_bits = ^acc_info[LOCK_BIT-1:PIN_MSB+1];

    atm_idle_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_idle_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .en     (timer_en),
        .expired(timer_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            card_q     <= 1'b0;
            shadow_pin <= '0;
            shadow_bal <= '0;
            amt_q      <= '0;
            tries      <= '0;
            acc_addr   <= '0;
            lock_acc   <= 1'b0;
            update     <= 1'b0;
            balance    <= '0;
            dispense   <= 1'b0;
            disp_amt   <= '0;
            bal_out    <= '0;
            status     <= '0;
            status_vld <= 1'b0;
        end else begin
            state      <= state_nxt;
            card_q     <= card_valid;
            shadow_pin <= pin_nxt;
            shadow_bal <= sbal_nxt;
            amt_q      <= amt_nxt;
            tries      <= tries_nxt;
            acc_addr   <= acc_addr_nxt;
            lock_acc   <= lock_nxt;
            update     <= update_nxt;
            balance    <= balance_nxt;
            dispense   <= dispense_nxt;
            disp_amt   <= disp_amt_nxt;
            bal_out    <= bal_out_nxt;
            status     <= status_nxt;
            status_vld <= status_vld_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        pin_nxt        = shadow_pin;
        sbal_nxt       = shadow_bal;
        amt_nxt        = amt_q;
        tries_nxt      = tries;
        acc_addr_nxt   = acc_addr;
        lock_nxt       = 1'b0;
        update_nxt     = 1'b0;
        dispense_nxt   = 1'b0;
        status_vld_nxt = 1'b0;
        balance_nxt    = balance;
        disp_amt_nxt   = disp_amt;
        bal_out_nxt    = bal_out;
        status_nxt     = status;

        // Card removal wins over strobes, except that a written debit always pays out.
        if (state != ST_IDLE && state != ST_DEBIT && !card_valid) begin
            state_nxt = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (card_rise) begin
                        if (card_acc > LAST_ACC) begin
                            status_nxt     = STAT_BAD_ACC;
                            status_vld_nxt = 1'b1;
                            state_nxt      = ST_EJECT;
                        end else begin
                            acc_addr_nxt = card_acc;
                            tries_nxt    = '0;
                            state_nxt    = ST_FETCH_ADDR;
                        end
                    end
                end
                ST_FETCH_ADDR: state_nxt = ST_FETCH_DATA;
                ST_FETCH_DATA: begin
                    pin_nxt  = word_pin(acc_info);
                    sbal_nxt = word_bal(acc_info);
                    if (acc_info[LOCK_BIT]) begin
                        status_nxt     = STAT_LOCKED;
                        status_vld_nxt = 1'b1;
                        state_nxt      = ST_EJECT;
                    end else begin
                        bal_out_nxt = word_bal(acc_info);
                        state_nxt   = ST_WAIT_PIN;
                    end
                end
                ST_WAIT_PIN: begin
                    if (pin_valid) begin
                        status_vld_nxt = 1'b1;
                        if (pin_digits == shadow_pin) begin
                            status_nxt = STAT_OK;
                            state_nxt  = ST_MENU;
                        end else begin
                            tries_nxt = tries_inc;
                            if (tries_inc >= TRY_W'(MAX_TRIES)) begin
                                lock_nxt   = 1'b1;
                                status_nxt = STAT_LOCKED;
                                state_nxt  = ST_LOCK;
                            end else begin
                                status_nxt = STAT_BAD_PIN;
                            end
                        end
                    end else if (timer_expired) begin
                        status_nxt     = STAT_TIMEOUT;
                        status_vld_nxt = 1'b1;
                        state_nxt      = ST_EJECT;
                    end
                end
                ST_LOCK: state_nxt = ST_EJECT;
                ST_MENU: begin
                    if (req_valid) begin
                        if (!req_wd) begin
                            status_nxt     = STAT_OK;
                            status_vld_nxt = 1'b1;
                        end else if (req_amt == '0 || req_amt > MAX_AMT) begin
                            status_nxt     = STAT_BAD_AMT;
                            status_vld_nxt = 1'b1;
                        end else if (req_amt > shadow_bal) begin
                            status_nxt     = STAT_INSUFF;
                            status_vld_nxt = 1'b1;
                        end else begin
                            balance_nxt = shadow_bal - req_amt;
                            update_nxt  = 1'b1;
                            amt_nxt     = req_amt;
                            state_nxt   = ST_DEBIT;
                        end
                    end else if (timer_expired) begin
                        status_nxt     = STAT_TIMEOUT;
                        status_vld_nxt = 1'b1;
                        state_nxt      = ST_EJECT;
                    end
                end
                ST_DEBIT: begin
                    dispense_nxt   = 1'b1;
                    disp_amt_nxt   = amt_q;
                    sbal_nxt       = balance;
                    bal_out_nxt    = balance;
                    status_nxt     = STAT_OK;
                    status_vld_nxt = 1'b1;
                    state_nxt      = card_valid ? ST_MENU : ST_IDLE;
                end
                ST_EJECT: state_nxt = ST_EJECT;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_atm_txn_ctrl.sv
// Scoreboard bench for atm_txn_ctrl: a session-level model queues the expected bus
// events and statuses; a negedge monitor compares whatever the DUT presents.
module tb_atm_txn_ctrl;
    localparam int NUM_ACC     = 5;
    localparam int MAX_TRIES   = 3;
    localparam int MAX_WD      = 500;
    localparam int TIMEOUT_CYC = 1024;

    localparam int S_OK = 0, S_BAD_PIN = 1, S_LOCKED = 2, S_INSUFF = 3;
    localparam int S_BAD_AMT = 4, S_BAD_ACC = 5, S_TIMEOUT = 6;
    localparam int EV_LOCK = 0, EV_UPD = 1, EV_DISP = 2, EV_STAT = 3;
    localparam int SS_NONE = 0, SS_PIN = 1, SS_MENU = 2, SS_EJECT = 3;

    logic        clk, rst;
    logic        card_valid, pin_valid, req_valid, req_wd;
    logic [4:0]  card_acc;
    logic [3:0]  pin_digits;
    logic [9:0]  req_amt;
    logic [31:0] acc_info;
    logic [4:0]  acc_addr;
    logic        lock_acc, update, dispense, status_vld, busy;
    logic [9:0]  balance, disp_amt, bal_out;
    logic [2:0]  status;

    atm_txn_ctrl #(
        .NUM_ACC(NUM_ACC), .MAX_TRIES(MAX_TRIES), .MAX_WD(MAX_WD), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst(rst), .card_valid(card_valid), .card_acc(card_acc),
        .pin_valid(pin_valid), .pin_digits(pin_digits), .req_valid(req_valid),
        .req_wd(req_wd), .req_amt(req_amt), .acc_info(acc_info), .acc_addr(acc_addr),
        .lock_acc(lock_acc), .update(update), .balance(balance), .dispense(dispense),
        .disp_amt(disp_amt), .bal_out(bal_out), .status(status),
        .status_vld(status_vld), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Account RAM: registered read, bench-side preload port, DUT lock/balance writes.
    logic        cfg_we;
    logic [4:0]  cfg_addr;
    logic [31:0] cfg_data;
    logic [31:0] ram [0:31];
    always @(posedge clk) begin
        if (cfg_we) ram[cfg_addr] <= cfg_data;
        else if (lock_acc) ram[acc_addr][31] <= 1'b1;
        else if (update) ram[acc_addr][9:0] <= balance;
        acc_info <= ram[acc_addr];
    end

    typedef struct { int kind; int a; int b; } ev_t;
    ev_t         exp_q[$];
    logic [31:0] exp_ram [0:31];
    int          sess = SS_NONE, cur = 0, tries = 0, disp = 0;
    int          last_strobe = 0;
    logic        chk_zero = 1'b0, chk_busy0 = 1'b0, done_req = 1'b0;

    // ---------------- monitor / checker ----------------
    int total = 0, bad = 0, rd_idx = 0;

    task automatic cmp(input string nm, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, want);
        end
    endtask

    task automatic see(input int kind, input int a, input int b);
        total++;
        if (rd_idx >= exp_q.size()) begin
            bad++;
            $display("FAIL unexpected_event: got kind=%0d a=%0d b=%0d, expected none (cyc %0d)",
                     kind, a, b, cyc);
        end else begin
            if (exp_q[rd_idx].kind != kind || exp_q[rd_idx].a != a || exp_q[rd_idx].b != b) begin
                bad++;
                $display("FAIL event_%0d: got kind=%0d a=%0d b=%0d, expected kind=%0d a=%0d b=%0d (cyc %0d)",
                         rd_idx, kind, a, b, exp_q[rd_idx].kind, exp_q[rd_idx].a, exp_q[rd_idx].b, cyc);
            end
            rd_idx++;
        end
    endtask

    always @(negedge clk) begin
        if (chk_zero) begin
            cmp("rst_acc_addr", int'(acc_addr), 0);
            cmp("rst_lock_acc", int'(lock_acc), 0);
            cmp("rst_update", int'(update), 0);
            cmp("rst_balance", int'(balance), 0);
            cmp("rst_dispense", int'(dispense), 0);
            cmp("rst_disp_amt", int'(disp_amt), 0);
            cmp("rst_bal_out", int'(bal_out), 0);
            cmp("rst_status", int'(status), 0);
            cmp("rst_status_vld", int'(status_vld), 0);
            cmp("rst_busy", int'(busy), 0);
        end else if (!rst) begin
            if (lock_acc) see(EV_LOCK, int'(acc_addr), 0);
            if (update) see(EV_UPD, int'(acc_addr), int'(balance));
            if (dispense) see(EV_DISP, 0, int'(disp_amt));
            if (status_vld) see(EV_STAT, int'(status), int'(bal_out));
            if (lock_acc || update || dispense)
                cmp("pulse_exclusive", int'((lock_acc && update) || (dispense && (lock_acc || update))), 0);
            if (status_vld && status == 3'(S_TIMEOUT)) begin
                total++;
                if (cyc - last_strobe < TIMEOUT_CYC - 1 || cyc - last_strobe > TIMEOUT_CYC + 3) begin
                    bad++;
                    $display("FAIL timeout_delay: got %0d cycles, expected about %0d",
                             cyc - last_strobe, TIMEOUT_CYC + 1);
                end
            end
        end
        if (chk_busy0) cmp("busy_after_removal", int'(busy), 0);
        if (done_req) begin
            for (int i = 0; i < NUM_ACC; i++) cmp($sformatf("ram_word_%0d", i), int'(ram[i]), int'(exp_ram[i]));
            cmp("events_drained", rd_idx, exp_q.size());
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    // ---------------- stimulus + session model ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic void push(input int kind, input int a, input int b);
        exp_q.push_back('{kind, a, b});
    endfunction

    function automatic logic [31:0] mkw(input bit lk, input int pin, input int bal, input int junk);
        return {lk, 17'(junk), 4'(pin), 10'(bal)};
    endfunction

    task automatic load(input int a, input logic [31:0] w);
        cfg_addr = 5'(a);
        cfg_data = w;
        cfg_we   = 1'b1;
        exp_ram[a] = w;
        tick(1);
        cfg_we = 1'b0;
    endtask

    task automatic insert(input int acc);
        card_acc   = 5'(acc);
        card_valid = 1'b1;
        if (acc >= NUM_ACC) begin
            push(EV_STAT, S_BAD_ACC, disp);
            sess = SS_EJECT;
        end else if (exp_ram[acc][31]) begin
            push(EV_STAT, S_LOCKED, disp);
            sess = SS_EJECT;
        end else begin
            cur   = acc;
            tries = 0;
            disp  = int'(exp_ram[acc][9:0]);
            sess  = SS_PIN;
        end
        tick(6);
    endtask

    task automatic remove();
        card_valid = 1'b0;
        sess = SS_NONE;
        tick(3);
    endtask

    task automatic enter_pin(input int p);
        pin_digits  = 4'(p);
        pin_valid   = 1'b1;
        last_strobe = cyc;
        if (sess == SS_PIN) begin
            if (p == int'(exp_ram[cur][13:10])) begin
                push(EV_STAT, S_OK, disp);
                sess = SS_MENU;
            end else begin
                tries++;
                if (tries >= MAX_TRIES) begin
                    push(EV_LOCK, cur, 0);
                    push(EV_STAT, S_LOCKED, disp);
                    exp_ram[cur][31] = 1'b1;
                    sess = SS_EJECT;
                end else begin
                    push(EV_STAT, S_BAD_PIN, disp);
                end
            end
        end
        tick(1);
        pin_valid = 1'b0;
        tick(3 + $urandom_range(0, 2));
    endtask

    // mode 0: normal; 1: card pulled the cycle after the request; 2: pulled in the same cycle
    task automatic request(input bit wd, input int amt, input int mode);
        int bal;
        req_wd      = wd;
        req_amt     = 10'(amt);
        req_valid   = 1'b1;
        last_strobe = cyc;
        if (mode == 2) begin
            card_valid = 1'b0;
            sess = SS_NONE;
        end else if (sess == SS_MENU) begin
            bal = int'(exp_ram[cur][9:0]);
            if (!wd) push(EV_STAT, S_OK, disp);
            else if (amt == 0 || amt > MAX_WD) push(EV_STAT, S_BAD_AMT, disp);
            else if (amt > bal) push(EV_STAT, S_INSUFF, disp);
            else begin
                push(EV_UPD, cur, bal - amt);
                push(EV_DISP, 0, amt);
                exp_ram[cur][9:0] = 10'(bal - amt);
                disp = bal - amt;
                push(EV_STAT, S_OK, disp);
            end
        end
        tick(1);
        req_valid = 1'b0;
        if (mode == 1) begin
            card_valid = 1'b0;
            sess = SS_NONE;
        end
        tick(3 + $urandom_range(0, 2));
    endtask

    initial begin
        rst = 1'b1; card_valid = 1'b0; card_acc = '0; pin_valid = 1'b0; pin_digits = '0;
        req_valid = 1'b0; req_wd = 1'b0; req_amt = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        tick(3);
        chk_zero = 1'b1;
        tick(1);
        chk_zero = 1'b0;
        for (int i = 0; i < 32; i++) load(i, 32'h0);
        load(0, mkw(1'b0, 4'h9, 100, 17'h15a5a));
        load(1, mkw(1'b0, 4'h3, 50, 0));
        load(2, mkw(1'b0, 4'h7, 300, 0));
        load(3, mkw(1'b0, 4'hA, 777, 17'h00ff0));
        load(4, mkw(1'b0, 4'h5, 400, 0));
        rst = 1'b0;
        tick(2);

        // basic withdrawal
        insert(2); enter_pin(7); request(1'b1, 120, 0); remove();
        // three wrong PINs lock the account; reinsertion reports LOCKED
        insert(1); enter_pin(0); enter_pin(1); enter_pin(2); remove();
        insert(1); remove();
        // amount boundaries
        insert(0); enter_pin(9);
        request(1'b1, 101, 0); request(1'b1, 100, 0); request(1'b1, 0, 0);
        request(1'b1, 501, 0); request(1'b0, 0, 0); remove();
        // out-of-range card
        insert(7); remove();
        // card pulled while the debit is in flight
        insert(4); enter_pin(5); request(1'b1, 150, 1);
        chk_busy0 = 1'b1; tick(1); chk_busy0 = 1'b0;
        // card pulled in the same cycle as a request
        insert(4); enter_pin(5); request(1'b1, 10, 2);
        chk_busy0 = 1'b1; tick(1); chk_busy0 = 1'b0;
        // inactivity timeout in MENU
        insert(3); enter_pin(4'hA);
        push(EV_STAT, S_TIMEOUT, disp);
        sess = SS_EJECT;
        tick(TIMEOUT_CYC + 10);
        remove();
        // reset during WAIT_PIN clears the try count
        insert(3); enter_pin(0); enter_pin(1);
        rst = 1'b1; card_valid = 1'b0; sess = SS_NONE; disp = 0;
        tick(2);
        chk_zero = 1'b1; tick(1); chk_zero = 1'b0;
        rst = 1'b0;
        tick(2);
        insert(3); enter_pin(2); enter_pin(4); enter_pin(4'hA); remove();

        // randomized sessions on freshly randomized accounts
        for (int i = 0; i < NUM_ACC; i++)
            load(i, mkw($urandom_range(0, 9) == 0, $urandom_range(0, 15),
                        $urandom_range(0, 1023), $urandom_range(0, 131071)));
        for (int s = 0; s < 40; s++) begin
            int acc, nops;
            acc  = $urandom_range(0, 6);
            nops = $urandom_range(1, 6);
            insert(acc);
            for (int k = 0; k < nops; k++) begin
                if (sess == SS_PIN || $urandom_range(0, 3) == 0) begin
                    if (acc < NUM_ACC && $urandom_range(0, 3) != 0) enter_pin(int'(exp_ram[acc][13:10]));
                    else enter_pin($urandom_range(0, 15));
                end else begin
                    int amt;
                    case ($urandom_range(0, 3))
                        0:       amt = int'(exp_ram[cur][9:0]);
                        1:       amt = $urandom_range(0, 20);
                        2:       amt = $urandom_range(0, 600);
                        default: amt = $urandom_range(490, 520);
                    endcase
                    request($urandom_range(0, 3) != 0, amt, 0);
                end
            end
            remove();
        end

        tick(4);
        done_req = 1'b1;
        tick(5);
        $display("FAIL end_of_run: monitor did not close the run");
        $fatal(1);
    end

endmodule
